// File: rtl/xgpon_sync_pkg.sv
// Shared types and default constants for the XG-PON downstream PSync frame synchroniser.
package xgpon_sync_pkg;

  localparam int unsigned FrameWordsDefault = 19440;
  localparam int unsigned SyncM1Default     = 2;
  localparam int unsigned SyncM2Default     = 3;

  localparam int unsigned WordCntW  = 15;
  localparam int unsigned MatchCntW = 8;
  localparam int unsigned LossCntW  = 16;

  typedef enum logic [1:0] {
    StHunt    = 2'd0,
    StPresync = 2'd1,
    StSync    = 2'd2
  } sync_state_e;

endpackage

// File: rtl/xgpon_frame_ctr.sv
// Valid-word counter for one downstream frame; flags the word at index 0 as the frame boundary.
module xgpon_frame_ctr
  import xgpon_sync_pkg::*;
#(
  parameter int unsigned FrameWords = FrameWordsDefault
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  input  logic restart_i,
  output logic boundary_o
);

  localparam logic [WordCntW-1:0] LastIdx = WordCntW'(FrameWords - 1);

  logic [WordCntW-1:0] count_d, count_q;
  logic [WordCntW-1:0] base;

  // restart_i treats the current word as index 0, so the next valid word is index 1
  always_comb begin
    base    = restart_i ? '0 : count_q;
    count_d = count_q;
    if (valid_i) begin
      count_d = (base == LastIdx) ? '0 : base + WordCntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign boundary_o = valid_i && (count_q == '0);

endmodule

// File: rtl/xgpon_sync_ctrl.sv
// XG-PON downstream PSync HUNT/PRESYNC/SYNC state machine with registered outputs.
// Define XGPON_SYNC_STATS_EN to add the saturating loss_count_out statistic.
module xgpon_sync_ctrl
  import xgpon_sync_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = FrameWordsDefault,
  parameter int unsigned SYNC_M1     = SyncM1Default,
  parameter int unsigned SYNC_M2     = SyncM2Default
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic                word_valid_in,
  input  logic                psync_hit_in,
  input  logic [5:0]          offset_in,
  input  logic                resync_in,
  output logic                hunt_out,
  output logic [5:0]          align_offset_out,
  output logic                offset_load_out,
  output logic [1:0]          sync_state_out,
  output logic                in_sync_out,
  output logic                frame_start_out,
  output logic                lost_sync_out
`ifdef XGPON_SYNC_STATS_EN
  ,
  output logic [LossCntW-1:0] loss_count_out
`endif
);

  localparam logic [MatchCntW-1:0] M1 = MatchCntW'(SYNC_M1);
  localparam logic [MatchCntW-1:0] M2 = MatchCntW'(SYNC_M2);

  sync_state_e          state_d, state_q;
  logic [MatchCntW-1:0] match_d, match_q;
  logic [MatchCntW-1:0] miss_d, miss_q;
  logic [MatchCntW-1:0] match_inc, miss_inc;
  logic [5:0]           align_d, align_q;
  logic                 load_d, load_q;
  logic                 frame_start_d, frame_start_q;
  logic                 lost_d, lost_q;
  logic                 hunt_d, hunt_q;
  logic                 in_sync_d, in_sync_q;
  logic                 hit, locked_hit, boundary, restart;

  xgpon_frame_ctr #(
    .FrameWords (FRAME_WORDS)
  ) u_frame_ctr (
    .clk_i      (clk_in),
    .rst_i      (reset_in),
    .valid_i    (word_valid_in),
    .restart_i  (restart),
    .boundary_o (boundary)
  );

  assign hit        = word_valid_in & psync_hit_in;
  assign locked_hit = hit && (offset_in == align_q);
  assign match_inc  = match_q + MatchCntW'(1);
  assign miss_inc   = miss_q + MatchCntW'(1);

  // frame_start fires for every boundary that leaves the block in SYNC, including the
  // confirming boundary that enters SYNC
  always_comb begin
    state_d       = state_q;
    match_d       = match_q;
    miss_d        = miss_q;
    align_d       = align_q;
    load_d        = 1'b0;
    frame_start_d = 1'b0;
    lost_d        = 1'b0;
    restart       = 1'b0;

    if (resync_in) begin
      state_d = StHunt;
      match_d = '0;
      miss_d  = '0;
    end else begin
      unique case (state_q)
        StHunt: begin
          if (hit) begin
            align_d = offset_in;
            load_d  = 1'b1;
            restart = 1'b1;
            match_d = MatchCntW'(1);
            miss_d  = '0;
            if (M1 <= MatchCntW'(1)) begin
              state_d       = StSync;
              frame_start_d = 1'b1;
            end else begin
              state_d = StPresync;
            end
          end
        end
        StPresync: begin
          if (boundary) begin
            if (locked_hit) begin
              match_d = match_inc;
              if (match_inc >= M1) begin
                state_d       = StSync;
                miss_d        = '0;
                frame_start_d = 1'b1;
              end
            end else begin
              state_d = StHunt;
              match_d = '0;
            end
          end
        end
        StSync: begin
          if (boundary) begin
            if (locked_hit) begin
              miss_d        = '0;
              frame_start_d = 1'b1;
            end else if (miss_inc >= M2) begin
              state_d = StHunt;
              match_d = '0;
              miss_d  = '0;
              lost_d  = 1'b1;
            end else begin
              miss_d        = miss_inc;
              frame_start_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = StHunt;
          match_d = '0;
          miss_d  = '0;
        end
      endcase
    end
  end

  assign hunt_d    = (state_d == StHunt);
  assign in_sync_d = (state_d == StSync);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q       <= StHunt;
      match_q       <= '0;
      miss_q        <= '0;
      align_q       <= '0;
      load_q        <= 1'b0;
      frame_start_q <= 1'b0;
      lost_q        <= 1'b0;
      hunt_q        <= 1'b1;
      in_sync_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      match_q       <= match_d;
      miss_q        <= miss_d;
      align_q       <= align_d;
      load_q        <= load_d;
      frame_start_q <= frame_start_d;
      lost_q        <= lost_d;
      hunt_q        <= hunt_d;
      in_sync_q     <= in_sync_d;
    end
  end

  assign hunt_out         = hunt_q;
  assign align_offset_out = align_q;
  assign offset_load_out  = load_q;
  assign sync_state_out   = state_q;
  assign in_sync_out      = in_sync_q;
  assign frame_start_out  = frame_start_q;
  assign lost_sync_out    = lost_q;

`ifdef XGPON_SYNC_STATS_EN
  logic [LossCntW-1:0] loss_d, loss_q;

  // Counts in step with the lost_sync pulse; saturates rather than wrapping
  always_comb begin
    loss_d = loss_q;
    if (lost_d && (loss_q != '1)) begin
      loss_d = loss_q + LossCntW'(1);
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign loss_count_out = loss_q;
`endif

endmodule
